// File: rtl/rf_wb_arb_if.sv
// Purpose : write-back bundle between two requesters (A = ALU, B = load) and
//           the register file write port, plus the arbiter's status outputs.
// Latency : none; plain wires.
// Backpr. : level req held until one-cycle ack; no credits, no queueing.
// Ports   : a_*/b_* request side (req/reg/data in, ack out); write_reg/write_data/
//           rf_we to the register file; busy, pend_reg, wr_count as status.
interface rf_wb_arb_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          a_req;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] a_data;
  logic          a_ack;
  logic          b_req;
  logic [AW-1:0] b_reg;
  logic [DW-1:0] b_data;
  logic          b_ack;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          rf_we;
  logic          busy;
  logic [AW-1:0] pend_reg;
  logic [15:0]   wr_count;

  // Requester / register-file side.
  modport master (
    output a_req, a_reg, a_data, b_req, b_reg, b_data,
    input  a_ack, b_ack, write_reg, write_data, rf_we, busy, pend_reg, wr_count
  );

  // Arbiter side.
  modport slave (
    input  a_req, a_reg, a_data, b_req, b_reg, b_data,
    output a_ack, b_ack, write_reg, write_data, rf_we, busy, pend_reg, wr_count
  );
endinterface

// File: rtl/rf_wb_arb.sv
// Purpose : round-robin write-back arbiter/sequencer for the 16x32 register file
//           write port: latch winner, setup cycle, one-cycle rf_we, release+ack.
// Latency : grant edge G -> rf_we high G+1..G+2 -> ack G+2..G+3 -> IDLE at G+3
//           (skipped R0 write: ack G+1..G+2, IDLE at G+2).
// Backpr. : requests are level-held; while busy all requests wait, nothing lost.
// Ports   : clk, rst_f (async active-low); bus = rf_wb_arb_if.slave carrying
//           the A/B request/ack pairs, register-file write port and status.
module rf_wb_arb #(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int SKIP_R0 = 1
) (
  input  logic       clk,
  input  logic       rst_f,
  rf_wb_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          last_b_q, last_b_d;   // 1: B held the most recent grant
  logic          win_b_q, win_b_d;     // owner of the operation in flight
  logic [AW-1:0] reg_q, reg_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   wr_count_q, wr_count_d;
  logic          rf_we_q, rf_we_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          busy_q, busy_d;
  logic          grant_b;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    win_b_d  = win_b_q;
    reg_d    = reg_q;
    data_d   = data_q;
    grant_b  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          // B wins when it is alone, or on a tie when A had the last grant.
          grant_b  = bus.b_req & ~(bus.a_req & last_b_q);
          win_b_d  = grant_b;
          last_b_d = grant_b;
          reg_d    = grant_b ? bus.b_reg  : bus.a_reg;
          data_d   = grant_b ? bus.b_data : bus.a_data;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        // R0 is hard-wired zero in the file; skip the strobe but still ack.
        if ((SKIP_R0 != 0) && (reg_q == '0)) begin
          state_d = RELEASE;
        end else begin
          state_d = STROBE;
        end
      end
      STROBE:  state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // All visible outputs are decoded from the next state and registered,
    // so rf_we / acks / busy come straight off flops.
    rf_we_d    = (state_d == STROBE);
    a_ack_d    = (state_d == RELEASE) && !win_b_d;
    b_ack_d    = (state_d == RELEASE) &&  win_b_d;
    busy_d     = (state_d != IDLE);
    // STROBE is entered only from SETUP and lasts one cycle: one count per pulse.
    wr_count_d = wr_count_q + {15'd0, rf_we_d};
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;   // A wins the first tie
      win_b_q    <= 1'b0;
      reg_q      <= '0;
      data_q     <= '0;
      wr_count_q <= '0;
      rf_we_q    <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      win_b_q    <= win_b_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
      rf_we_q    <= rf_we_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.a_ack      = a_ack_q;
  assign bus.b_ack      = b_ack_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.busy       = busy_q;
  assign bus.write_reg  = reg_q;
  assign bus.write_data = data_q;
  assign bus.pend_reg   = reg_q;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Purpose : self-checking bench for rf_wb_arb: directed scenarios with literal
//           expectations plus randomized requesters against a behavioural model.
// Latency : n/a.
// Backpr. : requesters hold req until ack, then drop or re-request.
module tb_rf_wb_arb;

  logic clk = 1'b0;
  logic rst_f;
  always #5 clk = ~clk;

  rf_wb_arb_if #(.DW(32), .AW(4)) bus  ();
  rf_wb_arb_if #(.DW(32), .AW(4)) bus0 ();

  rf_wb_arb #(.DW(32), .AW(4), .SKIP_R0(1)) u_dut  (.clk(clk), .rst_f(rst_f), .bus(bus));
  rf_wb_arb #(.DW(32), .AW(4), .SKIP_R0(0)) u_dut0 (.clk(clk), .rst_f(rst_f), .bus(bus0));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit pre = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of u_dut (SKIP_R0=1) ----------------
  // One operation = a grant plus a fixed timeline counted in cycles since the
  // grant: cycle 1 setup, cycle 2 strobe, cycle 3 ack; R0 writes drop the strobe.
  bit          m_busy, m_skip, m_win_b, m_last_b;
  int          m_ph;
  logic [3:0]  m_reg;
  logic [31:0] m_data;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      m_busy = 0; m_skip = 0; m_win_b = 0; m_last_b = 1; m_ph = 0;
      m_reg = 0; m_data = 0; m_cnt = 0;
    end else begin
      if (pre) m_cnt = 16'hFFFF;
      if (!m_busy) begin
        if (bus.a_req || bus.b_req) begin
          m_win_b  = (bus.a_req && bus.b_req) ? !m_last_b : bus.b_req;
          m_last_b = m_win_b;
          m_reg    = m_win_b ? bus.b_reg : bus.a_reg;
          m_data   = m_win_b ? bus.b_data : bus.a_data;
          m_skip   = (m_reg == 4'd0);
          m_busy   = 1;
          m_ph     = 1;
        end
      end else begin
        m_ph = m_ph + 1;
        if (m_ph == 2 && !m_skip) m_cnt = m_cnt + 16'd1;
        if (m_ph == (m_skip ? 3 : 4)) m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_f && chk_en) begin
      chk("m_rf_we",   32'(bus.rf_we), 32'(m_busy && !m_skip && m_ph == 2));
      chk("m_a_ack",   32'(bus.a_ack), 32'(m_busy && !m_win_b && m_ph == (m_skip ? 2 : 3)));
      chk("m_b_ack",   32'(bus.b_ack), 32'(m_busy &&  m_win_b && m_ph == (m_skip ? 2 : 3)));
      chk("m_busy",    32'(bus.busy), 32'(m_busy));
      chk("m_wreg",    32'(bus.write_reg), 32'(m_reg));
      chk("m_pend",    32'(bus.pend_reg), 32'(m_reg));
      chk("m_wdata",   bus.write_data, m_data);
      chk("m_wrcount", 32'(bus.wr_count), 32'(m_cnt));
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic new_a();
    bus.a_reg  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    bus.a_data = $urandom;
  endtask

  task automatic new_b();
    bus.b_reg  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    bus.b_data = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(bus.rf_we), 32'd0);
    chk({tag, "_aack"},  32'(bus.a_ack), 32'd0);
    chk({tag, "_back"},  32'(bus.b_ack), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_wreg"},  32'(bus.write_reg), 32'd0);
    chk({tag, "_wdata"}, bus.write_data, 32'd0);
    chk({tag, "_pend"},  32'(bus.pend_reg), 32'd0);
    chk({tag, "_cnt"},   32'(bus.wr_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pc[4];
    logic [3:0]  pr[4];
    int          np, n, ack1, we1, we0k, ack0k;
    bit          done;

    rst_f = 1'b0;
    bus.a_req = 0;  bus.a_reg = 0;  bus.a_data = 0;
    bus.b_req = 0;  bus.b_reg = 0;  bus.b_data = 0;
    bus0.a_req = 0; bus0.a_reg = 0; bus0.a_data = 0;
    bus0.b_req = 0; bus0.b_reg = 0; bus0.b_data = 0;
    for (int i = 0; i < 4; i++) begin pc[i] = 0; pr[i] = 0; end

    repeat (3) step();
    #1;
    chk_all_zero("rst");

    // ---- single write, request raised together with reset release ----
    step();
    rst_f = 1'b1;
    bus.a_req = 1; bus.a_reg = 4'd5; bus.a_data = 32'hDEADBEEF;
    chk_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (bus.a_ack) bus.a_req = 0;
      samp();
      case (k)
        1: begin
          chk("t1_wreg", 32'(bus.write_reg), 32'd5);
          chk("t1_wdata", bus.write_data, 32'hDEADBEEF);
          chk("t1_busy", 32'(bus.busy), 32'd1);
          chk("t1_we_setup", 32'(bus.rf_we), 32'd0);
        end
        2: begin
          chk("t1_we_strobe", 32'(bus.rf_we), 32'd1);
          chk("t1_cnt", 32'(bus.wr_count), 32'd1);
        end
        3: begin
          chk("t1_we_release", 32'(bus.rf_we), 32'd0);
          chk("t1_ack", 32'(bus.a_ack), 32'd1);
        end
        default: begin
          chk("t1_busy_end", 32'(bus.busy), 32'd0);
          chk("t1_ack_end", 32'(bus.a_ack), 32'd0);
        end
      endcase
    end

    // ---- tie and round-robin, both held through reset ----
    step();
    rst_f = 1'b0;
    bus.a_req = 1; bus.a_reg = 4'd1; bus.a_data = 32'h11;
    bus.b_req = 1; bus.b_reg = 4'd2; bus.b_data = 32'h22;
    step();
    rst_f = 1'b1;
    np = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      if (np >= 4 && bus.b_ack) begin
        bus.a_req = 0; bus.b_req = 0; done = 1;
        chk("rr_cnt", 32'(bus.wr_count), 32'd4);
      end
      samp();
      if (bus.rf_we) begin
        if (np < 4) begin pr[np] = bus.pend_reg; pc[np] = c; end
        np++;
      end
    end
    chk("rr_done", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) chk("rr_pend", 32'(pr[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    for (int i = 1; i < 4; i++) chk("rr_gap", 32'(pc[i] - pc[i-1]), 32'd4);

    // ---- R0 write: skipped on u_dut, performed on u_dut0 ----
    step();
    bus.b_req = 1;  bus.b_reg = 4'd0;  bus.b_data = 32'h12345678;
    bus0.b_req = 1; bus0.b_reg = 4'd0; bus0.b_data = 32'h12345678;
    ack1 = -1; we1 = 0; we0k = -1; ack0k = -1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (bus.b_ack) bus.b_req = 0;
      if (bus0.b_ack) bus0.b_req = 0;
      samp();
      if (bus.rf_we) we1++;
      if (bus.b_ack && ack1 < 0) ack1 = k;
      if (bus0.rf_we && we0k < 0) we0k = k;
      if (bus0.b_ack && ack0k < 0) ack0k = k;
    end
    chk("r0_we_skip", 32'(we1), 32'd0);
    chk("r0_ack_skip", 32'(ack1), 32'd2);
    chk("r0_cnt_skip", 32'(bus.wr_count), 32'd4);
    chk("r0_we_noskip", 32'(we0k), 32'd2);
    chk("r0_ack_noskip", 32'(ack0k), 32'd3);
    chk("r0_cnt_noskip", 32'(bus0.wr_count), 32'd1);

    // ---- requester data changes after the grant ----
    step();
    bus.a_req = 1; bus.a_reg = 4'd9; bus.a_data = 32'hCAFEF00D;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) bus.a_data = 32'hFFFFFFFF;
      if (bus.a_ack) bus.a_req = 0;
      samp();
      chk("inst_wdata", bus.write_data, 32'hCAFEF00D);
      if (k == 3) chk("inst_ack", 32'(bus.a_ack), 32'd1);
    end

    // ---- reset in the middle of a strobe ----
    step();
    bus.a_req = 1; bus.a_reg = 4'd7; bus.a_data = 32'h77;
    step();
    step();
    chk("mid_we_before", 32'(bus.rf_we), 32'd1);
    #2;
    rst_f = 1'b0;
    #1;
    chk_all_zero("mid");
    step();
    rst_f = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (bus.a_ack) bus.a_req = 0;
      samp();
      case (k)
        1: chk("mid_pend", 32'(bus.pend_reg), 32'd7);
        2: begin
          chk("mid_we", 32'(bus.rf_we), 32'd1);
          chk("mid_cnt", 32'(bus.wr_count), 32'd1);
        end
        3: chk("mid_ack", 32'(bus.a_ack), 32'd1);
        default: chk("mid_idle", 32'(bus.busy), 32'd0);
      endcase
    end

    // ---- counter wrap from a preloaded 0xFFFF ----
    step();
    chk_en = 1'b0;
    force u_dut.wr_count_q = 16'hFFFF;
    pre = 1'b1;
    step();
    release u_dut.wr_count_q;
    pre = 1'b0;
    chk_en = 1'b1;
    bus.a_req = 1; bus.a_reg = 4'd3; bus.a_data = 32'h3;
    samp();
    chk("wrap_pre", 32'(bus.wr_count), 32'hFFFF);
    n = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (n == 2 && bus.a_ack) begin bus.a_req = 0; done = 1; end
      samp();
      if (bus.rf_we) begin
        n++;
        if (n == 1) chk("wrap_zero", 32'(bus.wr_count), 32'h0000);
        if (n == 2) chk("wrap_one", 32'(bus.wr_count), 32'h0001);
      end
    end
    chk("wrap_n", 32'(n), 32'd2);

    // ---- randomized requesters ----
    for (int c = 0; c < 4000; c++) begin
      step();
      if (bus.a_req) begin
        if (bus.a_ack) begin
          if ($urandom_range(0, 1) == 1) new_a(); else bus.a_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.a_req = 1; new_a();
      end
      if (bus.b_req) begin
        if (bus.b_ack) begin
          if ($urandom_range(0, 1) == 1) new_b(); else bus.b_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.b_req = 1; new_b();
      end
    end

    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (bus.a_ack) bus.a_req = 0;
      if (bus.b_ack) bus.b_req = 0;
      if (!bus.a_req && !bus.b_req && !bus.busy) done = 1;
    end
    chk("drain_done", 32'(done), 32'd1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
